// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator and pixel output stage for a VGA DAC. A pair of
// horizontal/vertical counters walks the full raster (active area, front
// porch, sync, back porch). The counters are exposed as x_pos/y_pos together
// with a pixel request, so upstream drawing logic can supply the colour of the
// current pixel. That colour is registered on the same clock-enabled edge as
// the sync and blanking signals, so everything at the DAC pins moves together.
//
// Ports
//   clock        pixel clock, all logic on the rising edge
//   reset        synchronous, active-high; overrides ce
//   ce           pixel clock enable; nothing advances while low
//   pix_req      (x_pos,y_pos) lies inside the active area this cycle
//   x_pos/y_pos  current raster position straight from the counters
//   colour_*_in  colour for the requested pixel, sampled on the ce edge
//   line_start   high while x_pos==0 and ce==1
//   frame_start  high while x_pos==0, y_pos==0 and ce==1
//   vga_hsync    registered horizontal sync, HSYNC_POL is the asserted level
//   vga_vsync    registered vertical sync, VSYNC_POL is the asserted level
//   vga_blank_n  registered, low outside the active area
//   colour_*     registered colour to the DAC, zero while blanked
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 48,
  parameter int H_SYNC    = 112,
  parameter int H_BP      = 248,
  parameter int V_ACTIVE  = 1024,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 38,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int COORD_W   = 11,
  parameter int COLOUR_W  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ce,
  output logic                pix_req,
  output logic [COORD_W-1:0]  x_pos,
  output logic [COORD_W-1:0]  y_pos,
  input  logic [COLOUR_W-1:0] colour_R_in,
  input  logic [COLOUR_W-1:0] colour_G_in,
  input  logic [COLOUR_W-1:0] colour_B_in,
  output logic                line_start,
  output logic                frame_start,
  output logic                vga_hsync,
  output logic                vga_vsync,
  output logic                vga_blank_n,
  output logic [COLOUR_W-1:0] colour_R,
  output logic [COLOUR_W-1:0] colour_G,
  output logic [COLOUR_W-1:0] colour_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region boundaries are kept one bit wider than the counters. A sync region
  // that ends exactly at H_TOTAL (zero back porch) may equal 2**COORD_W, which
  // would wrap to zero at counter width and erase the whole region.
  localparam int EW = COORD_W + 1;

  localparam logic [EW-1:0] H_ACT_END  = EW'(H_ACTIVE);
  localparam logic [EW-1:0] H_SYNC_BEG = EW'(H_ACTIVE + H_FP);
  localparam logic [EW-1:0] H_SYNC_END = EW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [EW-1:0] H_LAST     = EW'(H_TOTAL - 1);

  localparam logic [EW-1:0] V_ACT_END  = EW'(V_ACTIVE);
  localparam logic [EW-1:0] V_SYNC_BEG = EW'(V_ACTIVE + V_FP);
  localparam logic [EW-1:0] V_SYNC_END = EW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [EW-1:0] V_LAST     = EW'(V_TOTAL - 1);

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic [EW-1:0]      h_ext;
  logic [EW-1:0]      v_ext;
  logic               h_last;
  logic               v_last;
  logic               hsync_raw;
  logic               vsync_raw;
  logic               active_raw;

  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};

  // Decode where the counters currently sit in the raster. An empty porch or
  // sync region has equal begin/end bounds, so it never matches and costs no
  // cycle.
  always_comb begin
    h_last     = (h_ext == H_LAST);
    v_last     = (v_ext == V_LAST);
    hsync_raw  = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
    vsync_raw  = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
    active_raw = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
  end

  // Raster counters. The line counter only moves when the pixel counter
  // wraps, which is why vsync changes on a line boundary rather than on an
  // hsync edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Output stage. The colour returned for the requested pixel and the syncs
  // decoded from the same counter values are captured on the same edge, so
  // the DAC sees colour, blanking and syncs for one pixel together. Reset
  // drops any sync pulse in progress at once instead of finishing it.
  always_ff @(posedge clock) begin
    if (reset) begin
      vga_hsync   <= ~HSYNC_POL;
      vga_vsync   <= ~VSYNC_POL;
      vga_blank_n <= 1'b0;
      colour_R    <= '0;
      colour_G    <= '0;
      colour_B    <= '0;
    end else if (ce) begin
      vga_hsync   <= hsync_raw ? HSYNC_POL : ~HSYNC_POL;
      vga_vsync   <= vsync_raw ? VSYNC_POL : ~VSYNC_POL;
      vga_blank_n <= active_raw;
      colour_R    <= active_raw ? colour_R_in : '0;
      colour_G    <= active_raw ? colour_G_in : '0;
      colour_B    <= active_raw ? colour_B_in : '0;
    end
  end

  // Position and request go out combinationally from the counter registers,
  // so upstream sees the request in the same cycle as the coordinates. The
  // start pulses are gated with ce so a held counter value yields one pulse.
  assign x_pos       = h_cnt;
  assign y_pos       = v_cnt;
  assign pix_req     = active_raw;
  assign line_start  = ce && (h_cnt == '0);
  assign frame_start = ce && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Bench for vga_timing_gen. Two small-raster instances (16x8 total, positive
// and negative sync polarity) share one set of stimulus. A default 1280x1024
// instance is used for a single-line timing check. The small raster is
// tracked by a step counter t (0..127) that is independent of the design's
// counter structure. Each driven cycle pushes the expected outputs into a
// queue, and a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clock;
  logic reset;
  logic ce;

  // Small raster, positive polarity
  logic        s_pix, s_ls, s_fs, s_hs, s_vs, s_bn;
  logic [3:0]  s_x, s_y;
  logic [7:0]  s_r_in, s_g_in, s_b_in, s_r, s_g, s_b;

  // Small raster, negative polarity
  logic        n_pix, n_ls, n_fs, n_hs, n_vs, n_bn;
  logic [3:0]  n_x, n_y;
  logic [7:0]  n_r_in, n_g_in, n_b_in, n_r, n_g, n_b;

  // Default 1280x1024 raster
  logic        d_pix, d_ls, d_fs, d_hs, d_vs, d_bn;
  logic [10:0] d_x, d_y;
  logic [7:0]  d_r_in, d_g_in, d_b_in, d_r, d_g, d_b;

  // Upstream colour is a pure function of the requested coordinates
  assign s_r_in = {4'h0, s_x};
  assign s_g_in = {4'h0, s_y} ^ 8'hA5;
  assign s_b_in = {s_x, s_y};
  assign n_r_in = {4'h0, n_x};
  assign n_g_in = {4'h0, n_y} ^ 8'hA5;
  assign n_b_in = {n_x, n_y};
  assign d_r_in = d_x[7:0];
  assign d_g_in = d_y[7:0];
  assign d_b_in = 8'h00;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COORD_W(4), .COLOUR_W(8)
  ) dut_pos (
    .clock(clock), .reset(reset), .ce(ce),
    .pix_req(s_pix), .x_pos(s_x), .y_pos(s_y),
    .colour_R_in(s_r_in), .colour_G_in(s_g_in), .colour_B_in(s_b_in),
    .line_start(s_ls), .frame_start(s_fs),
    .vga_hsync(s_hs), .vga_vsync(s_vs), .vga_blank_n(s_bn),
    .colour_R(s_r), .colour_G(s_g), .colour_B(s_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COORD_W(4), .COLOUR_W(8)
  ) dut_neg (
    .clock(clock), .reset(reset), .ce(ce),
    .pix_req(n_pix), .x_pos(n_x), .y_pos(n_y),
    .colour_R_in(n_r_in), .colour_G_in(n_g_in), .colour_B_in(n_b_in),
    .line_start(n_ls), .frame_start(n_fs),
    .vga_hsync(n_hs), .vga_vsync(n_vs), .vga_blank_n(n_bn),
    .colour_R(n_r), .colour_G(n_g), .colour_B(n_b)
  );

  vga_timing_gen dut_dflt (
    .clock(clock), .reset(reset), .ce(ce),
    .pix_req(d_pix), .x_pos(d_x), .y_pos(d_y),
    .colour_R_in(d_r_in), .colour_G_in(d_g_in), .colour_B_in(d_b_in),
    .line_start(d_ls), .frame_start(d_fs),
    .vga_hsync(d_hs), .vga_vsync(d_vs), .vga_blank_n(d_bn),
    .colour_R(d_r), .colour_G(d_g), .colour_B(d_b)
  );

  // 10-unit clock period, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int x;
    int y;
    int pix;
    int ls;
    int fs;
    int hs;
    int vs;
    int bn;
    int r;
    int g;
    int b;
  } exp_t;

  exp_t expQ[$];

  int testsRun = 0;
  int testsFailed = 0;

  // Reference state: t counts enabled steps since reset, wrapping every
  // 128 steps. The m* values are the expected registered outputs.
  int  mT = 0;
  bit  mValid = 0;
  int  mHs = 0, mVs = 0, mBn = 0, mR = 0, mG = 0, mB = 0;

  // Snapshots taken mid-cycle by applyStimulus, for the directed checks
  int snapX, snapY, snapHs, snapVs, snapBn, snapFs, snapNHs, snapNVs;
  int snapDHs, snapDVs, snapDLs;

  // Hand-derived regions of the 16x8 raster: sync at x 10..12, lines 5..6,
  // active when x<8 and y<4
  function automatic int refHsync(int t);
    return ((t % 16) >= 10 && (t % 16) <= 12) ? 1 : 0;
  endfunction

  function automatic int refVsync(int t);
    return ((t / 16) == 5 || (t / 16) == 6) ? 1 : 0;
  endfunction

  function automatic int refActive(int t);
    return ((t % 16) < 8 && (t / 16) < 4) ? 1 : 0;
  endfunction

  // Count one comparison and report it when it does not hold
  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one clock cycle: set inputs, capture snapshots, push the expected
  // outputs for this cycle, take the edge, then advance the reference
  task automatic applyStimulus(input bit r, input bit c);
    exp_t e;
    logic [7:0] yv;
    reset = r;
    ce = c;
    #2;
    snapX = int'(s_x);
    snapY = int'(s_y);
    snapHs = int'(s_hs);
    snapVs = int'(s_vs);
    snapBn = int'(s_bn);
    snapFs = int'(s_fs);
    snapNHs = int'(n_hs);
    snapNVs = int'(n_vs);
    snapDHs = int'(d_hs);
    snapDVs = int'(d_vs);
    snapDLs = int'(d_ls);
    if (mValid) begin
      e.x   = mT % 16;
      e.y   = mT / 16;
      e.pix = refActive(mT);
      e.ls  = (c && (mT % 16) == 0) ? 1 : 0;
      e.fs  = (c && mT == 0) ? 1 : 0;
      e.hs  = mHs;
      e.vs  = mVs;
      e.bn  = mBn;
      e.r   = mR;
      e.g   = mG;
      e.b   = mB;
      expQ.push_back(e);
    end
    @(posedge clock);
    if (r) begin
      mT = 0;
      mHs = 0; mVs = 0; mBn = 0; mR = 0; mG = 0; mB = 0;
      mValid = 1;
    end else if (c && mValid) begin
      mHs = refHsync(mT);
      mVs = refVsync(mT);
      mBn = refActive(mT);
      if (mBn == 1) begin
        yv = 8'(mT / 16) ^ 8'hA5;
        mR = mT % 16;
        mG = int'(yv);
        mB = (mT % 16) * 16 + (mT / 16);
      end else begin
        mR = 0; mG = 0; mB = 0;
      end
      mT = (mT + 1) % 128;
    end
    #1;
  endtask

  // Scoreboard monitor: one expected entry per cycle, compared on the
  // falling edge, well away from the rising edge where things change
  always @(negedge clock) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("x_pos",        int'(s_x),  e.x);
      checkOutput("y_pos",        int'(s_y),  e.y);
      checkOutput("pix_req",      int'(s_pix), e.pix);
      checkOutput("line_start",   int'(s_ls), e.ls);
      checkOutput("frame_start",  int'(s_fs), e.fs);
      checkOutput("vga_hsync",    int'(s_hs), e.hs);
      checkOutput("vga_vsync",    int'(s_vs), e.vs);
      checkOutput("vga_blank_n",  int'(s_bn), e.bn);
      checkOutput("colour_R",     int'(s_r),  e.r);
      checkOutput("colour_G",     int'(s_g),  e.g);
      checkOutput("colour_B",     int'(s_b),  e.b);
      checkOutput("neg vga_hsync", int'(n_hs), 1 - e.hs);
      checkOutput("neg vga_vsync", int'(n_vs), 1 - e.vs);
    end
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    int hsCount, hsFirst, vsCount, bnCount, fs0, fs1, dFirst, dWidth, dLs, dVs;
    reset = 1'b1;
    ce = 1'b1;

    // Reset, then check the state held in reset
    applyStimulus(1, 1);
    applyStimulus(1, 1);
    checkOutput("reset neg hsync idle", snapNHs, 1);
    checkOutput("reset neg vsync idle", snapNVs, 1);
    checkOutput("reset frame_start", snapFs, 1);

    // Two frames with ce held high
    hsCount = 0; hsFirst = -1; vsCount = 0; bnCount = 0; fs0 = -1; fs1 = -1;
    for (int k = 0; k < 256; k++) begin
      applyStimulus(0, 1);
      if (k < 16 && snapHs == 1) begin
        hsCount++;
        if (hsFirst < 0) hsFirst = k;
      end
      if (k < 128 && snapVs == 1) vsCount++;
      if (k < 128 && snapBn == 1) bnCount++;
      if (snapFs == 1) begin
        if (fs0 < 0) fs0 = k;
        else if (fs1 < 0) fs1 = k;
      end
    end
    checkOutput("hsync width", hsCount, 3);
    checkOutput("hsync first cycle", hsFirst, 11);
    checkOutput("vsync width", vsCount, 32);
    checkOutput("blank_n count", bnCount, 32);
    checkOutput("frame_start period", fs1 - fs0, 128);

    // ce alternating 1,0: frame and sync widths double in clocks
    applyStimulus(1, 1);
    hsCount = 0; hsFirst = -1; fs0 = -1; fs1 = -1;
    for (int k = 0; k < 300; k++) begin
      applyStimulus(0, (k % 2) == 0);
      if (k < 32 && snapHs == 1) begin
        hsCount++;
        if (hsFirst < 0) hsFirst = k;
      end
      if (snapFs == 1) begin
        if (fs0 < 0) fs0 = k;
        else if (fs1 < 0) fs1 = k;
      end
    end
    checkOutput("ce/2 hsync width", hsCount, 6);
    checkOutput("ce/2 hsync first", hsFirst, 21);
    checkOutput("ce/2 frame period", fs1 - fs0, 256);

    // Reset mid-frame at x=5, y=2
    applyStimulus(1, 1);
    for (int k = 0; k < 37; k++) applyStimulus(0, 1);
    applyStimulus(1, 1);
    checkOutput("pre-reset x", snapX, 5);
    checkOutput("pre-reset y", snapY, 2);
    applyStimulus(0, 1);
    checkOutput("post-reset x", snapX, 0);
    checkOutput("post-reset y", snapY, 0);
    checkOutput("post-reset frame_start", snapFs, 1);
    checkOutput("post-reset blank_n", snapBn, 0);

    // Reset while both syncs are asserted: they must drop at once
    for (int k = 0; k < 90; k++) applyStimulus(0, 1);
    applyStimulus(1, 1);
    checkOutput("in-sync hsync", snapHs, 1);
    checkOutput("in-sync vsync", snapVs, 1);
    applyStimulus(0, 1);
    checkOutput("reset drops hsync", snapHs, 0);
    checkOutput("reset drops vsync", snapVs, 0);
    checkOutput("reset drops neg hsync", snapNHs, 1);

    // One line of the default 1280x1024 timing
    applyStimulus(1, 1);
    dFirst = -1; dWidth = 0; dLs = -1; dVs = 0;
    for (int k = 0; k < 1700; k++) begin
      applyStimulus(0, 1);
      if (snapDHs == 1) begin
        dWidth++;
        if (dFirst < 0) dFirst = k;
      end
      if (k > 0 && snapDLs == 1 && dLs < 0) dLs = k;
      if (snapDVs == 1) dVs++;
    end
    checkOutput("default hsync start", dFirst, 1329);
    checkOutput("default hsync width", dWidth, 112);
    checkOutput("default line length", dLs, 1688);
    checkOutput("default vsync on line 0", dVs, 0);

    // Random ce with occasional resets, checked by the scoreboard only
    for (int k = 0; k < 300; k++) begin
      applyStimulus($urandom_range(0, 40) == 0, $urandom_range(0, 1) == 1);
    end

    @(negedge clock);
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
